mem_stall_ctrl: RTL and testbench

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/mem_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// Data-memory access controller: stalls the pipeline while a load/store is outstanding.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stall_ctrl #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wrdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rddata_o,
  output logic        stall_o,
  output logic        timeout_o
);

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              req_any;
  logic              start;
  logic              to_hit;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rddata_q;

  assign req_any = MemRead_i | MemWrite_i;
  assign start   = (state == IDLE) && req_any;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       timeout_q;

  // Limit is reached on the TIMEOUT_CYC-th ACCESS cycle; an ack in that cycle wins.
  assign to_hit = (state == ACCESS) && !mem_ack_i && (to_cnt == TIMEOUT_CYC - 8'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= 8'd0;
    end else if (start) begin
      to_cnt <= 8'd0;
    end else if ((state == ACCESS) && !mem_ack_i) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Set only on the forced ACCESS->DONE edge, so it is high for that DONE cycle alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign to_hit             = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE ignores the request lines: they still belong to the instruction just completed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_any) state_nxt = ACCESS;
      ACCESS:  if (mem_ack_i || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The IDLE stall term is combinational so the pipeline freezes in the request cycle.
  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    stall_o   = 1'b0;
    unique case (state)
      IDLE: begin
        stall_o = req_any & ~rst_i;
      end
      ACCESS: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
        stall_o   = 1'b1;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  // Write takes priority when both request lines are raised together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (start) begin
      addr_q  <= addr_i;
      wdata_q <= wrdata_i;
      we_q    <= MemWrite_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rddata_q <= '0;
    end else if ((state == ACCESS) && !we_q) begin
      if (mem_ack_i) begin
        rddata_q <= mem_rdata_i;
      end else if (to_hit) begin
        rddata_q <= ABORT_DATA;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rddata_o    = rddata_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl (timeout cases built when MEM_TIMEOUT_EN is defined).
module tb_mem_stall_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TCYC = 8'd4;
`else
  localparam logic [7:0] TCYC = 8'd255;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wrdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] rddata_o;
  logic        stall_o, timeout_o;

  int total = 0;
  int bad   = 0;

  mem_stall_ctrl #(.TIMEOUT_CYC(TCYC)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wrdata_i    (wrdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .rddata_o    (rddata_o),
    .stall_o     (stall_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // One full request: IDLE request cycle, acc_cycles ACCESS cycles (ack on the last), DONE, back to IDLE.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int acc_cycles, input logic [31:0] rdv,
                         input logic exp_we, input logic [31:0] exp_rd, input int exp_stalls);
    int stalls = 0;
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; wrdata_i = wd; mem_ack_i = 1'b0;
    #1;
    if (stall_o) stalls++;
    chk("idle_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    for (int i = 1; i <= acc_cycles; i++) begin
      addr_i      = ~a;
      wrdata_i    = ~wd;
      mem_ack_i   = (i == acc_cycles);
      mem_rdata_i = (i == acc_cycles) ? rdv : 32'hBAD0_0000 + 32'(i);
      #1;
      if (stall_o) stalls++;
      chk("acc_req", {31'd0, mem_req_o}, 32'd1);
      chk("acc_we", {31'd0, mem_we_o}, {31'd0, exp_we});
      chk("acc_addr", mem_addr_o, a);
      chk("acc_wdata", mem_wdata_o, wd);
      tick();
    end
    // DONE: request lines still high, spurious ack with junk data
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_0000;
    #1;
    chk("done_stall", {31'd0, stall_o}, 32'd0);
    chk("done_req", {31'd0, mem_req_o}, 32'd0);
    chk("done_rddata", rddata_o, exp_rd);
    chk("done_timeout", {31'd0, timeout_o}, 32'd0);
    chk("stall_len", 32'(stalls), 32'(exp_stalls));
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("post_req", {31'd0, mem_req_o}, 32'd0);
    chk("post_rddata", rddata_o, exp_rd);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    MemRead_i = 1'b1; MemWrite_i = 1'b0;
    addr_i = 32'h99; wrdata_i = 32'h0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    tick(); tick();
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rddata", rddata_o, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    MemRead_i = 1'b0; mem_ack_i = 1'b0;
    rst_i = 1'b0;
    tick();

    // read, ack in first ACCESS cycle
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h1234_5678, 1'b0, 32'h1234_5678, 2);
    // write, ack after 5 ACCESS cycles; read data ignored
    run_txn(1'b0, 1'b1, 32'h80, 32'hCAFE_0001, 5, 32'h5555_AAAA, 1'b1, 32'h1234_5678, 6);

    // spurious ack while idle
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD;
    tick(); tick();
    #1;
    chk("idle_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("idle_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("idle_ack_rddata", rddata_o, 32'h1234_5678);
    mem_ack_i = 1'b0;

    // read+write together: write wins
    run_txn(1'b1, 1'b1, 32'h84, 32'h0000_0BAD, 1, 32'h7777_7777, 1'b1, 32'h1234_5678, 2);

    // back-to-back loads
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h1111_1111, 1'b0, 32'h1111_1111, 3);
    run_txn(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h2222_2222, 1'b0, 32'h2222_2222, 2);

    // reset mid-ACCESS
    MemRead_i = 1'b1; addr_i = 32'h60;
    tick();
    #1;
    chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_addr", mem_addr_o, 32'd0);
    chk("midrst_rddata", rddata_o, 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hEEEE_EEEE;
    tick(); tick();
    rst_i = 1'b0; MemRead_i = 1'b0;
    tick();
    #1;
    chk("postrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("postrst_rddata", rddata_o, 32'd0);
    mem_ack_i = 1'b0;
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 2, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 3);

`ifdef MEM_TIMEOUT_EN
    // no ack: forced DONE after 4 ACCESS cycles
    MemRead_i = 1'b1; addr_i = 32'h200; mem_ack_i = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("to_acc_req", {31'd0, mem_req_o}, 32'd1);
      chk("to_acc_timeout", {31'd0, timeout_o}, 32'd0);
      tick();
    end
    #1;
    chk("to_done_req", {31'd0, mem_req_o}, 32'd0);
    chk("to_done_stall", {31'd0, stall_o}, 32'd0);
    chk("to_done_timeout", {31'd0, timeout_o}, 32'd1);
    chk("to_done_rddata", rddata_o, 32'hDEAD_BEEF);
    MemRead_i = 1'b0;
    tick();
    #1;
    chk("to_idle_timeout", {31'd0, timeout_o}, 32'd0);
    // ack exactly on the 4th ACCESS cycle wins
    run_txn(1'b1, 1'b0, 32'h204, 32'h0, 4, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 5);
`else
    // without the timeout, a long wait still completes on ack
    run_txn(1'b1, 1'b0, 32'h48, 32'h0, 10, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
